// File: rtl/norm_seq_fx.sv
// norm_seq_fx: post-processing unit for the fixed-point accumulator path.
// It applies one of three operations to a captured operand: pass-through,
// a positive-set clamp, or normalization by NUGAIN. Normalization uses an
// iterative restoring divider that produces one quotient bit per cycle.
// A start/busy/done handshake lets the core stall while a divide is running.
module norm_seq_fx #(
  parameter int                NUBITS = 32,
  parameter logic [NUBITS-1:0] NUGAIN = 128,
  parameter bit                NORMS  = 1'b1,
  parameter bit                PSET   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUBITS-1:0] acc,
  input  logic              neg,
  input  logic              norm,
  output logic              busy,
  output logic              done,
  output logic [NUBITS-1:0] out
);

  localparam int CNT_W = (NUBITS > 1) ? $clog2(NUBITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NUBITS-1:0] dvd_q, dvd_d;   // dividend, with quotient bits shifted in at the LSB
  logic [NUBITS-1:0] rem_q, rem_d;   // partial remainder, always < NUGAIN after a step
  logic [CNT_W-1:0]  cnt_q, cnt_d;   // iterations left after the current one
  logic [NUBITS-1:0] out_q, out_d;

  logic              is_div;
  logic [NUBITS-1:0] imm_res;
  logic [NUBITS:0]   rem_sh;
  logic [NUBITS:0]   rem_diff;
  logic              qbit;
  logic [NUBITS-1:0] rem_nx;
  logic [NUBITS-1:0] quo_nx;

  // Negative operands clamp to zero; non-negative ones pass unchanged.
  function automatic logic [NUBITS-1:0] pos_clamp(input logic [NUBITS-1:0] v);
    return v[NUBITS-1] ? '0 : v;
  endfunction

  // Decode the request and evaluate single-cycle results and one divide step.
  always_comb begin
    is_div   = NORMS && ({neg, norm} == 2'b01);
    imm_res  = (PSET && ({neg, norm} == 2'b10)) ? pos_clamp(acc) : acc;
    rem_sh   = {rem_q, dvd_q[NUBITS-1]};
    rem_diff = rem_sh - {1'b0, NUGAIN};
    // With NUGAIN = 0 this comparison is always true, giving an all-ones quotient.
    qbit     = (rem_sh >= {1'b0, NUGAIN});
    rem_nx   = qbit ? rem_diff[NUBITS-1:0] : rem_sh[NUBITS-1:0];
    quo_nx   = {dvd_q[NUBITS-2:0], qbit};
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE accepts start, DIV runs NUBITS steps, FIN lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = is_div ? S_DIV : S_FIN;
        end
      end
      S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_FIN);
  end

  // Datapath next-state: capture on accept, shift/subtract while dividing.
  always_comb begin
    dvd_d = dvd_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    out_d = out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_div) begin
            dvd_d = acc;
            rem_d = '0;
            cnt_d = CNT_W'(NUBITS - 1);
          end else begin
            out_d = imm_res;
          end
        end
      end
      S_DIV: begin
        dvd_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          out_d = quo_nx;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; out only changes on the edge entering FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_norm_seq_fx.sv
// Directed testbench for norm_seq_fx: main instance (NUGAIN=128), a
// NUGAIN=0 instance and a NORMS=0 instance.
module tb_norm_seq_fx;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, start_z = 1'b0, start_n = 1'b0;
  logic         neg = 1'b0, norm = 1'b0;
  logic [W-1:0] acc = '0;
  logic         busy, done, busy_z, done_z, busy_n, done_n;
  logic [W-1:0] out, out_z, out_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  norm_seq_fx #(.NUBITS(32), .NUGAIN(128), .NORMS(1'b1), .PSET(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .acc(acc), .neg(neg), .norm(norm),
    .busy(busy), .done(done), .out(out)
  );

  norm_seq_fx #(.NUBITS(32), .NUGAIN(0), .NORMS(1'b1), .PSET(1'b1)) dut_z (
    .clk(clk), .rst(rst), .start(start_z), .acc(acc), .neg(neg), .norm(norm),
    .busy(busy_z), .done(done_z), .out(out_z)
  );

  norm_seq_fx #(.NUBITS(32), .NUGAIN(128), .NORMS(1'b0), .PSET(1'b1)) dut_n (
    .clk(clk), .rst(rst), .start(start_n), .acc(acc), .neg(neg), .norm(norm),
    .busy(busy_n), .done(done_n), .out(out_n)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      1:       return done_z;
      2:       return done_n;
      default: return done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1:       return busy_z;
      2:       return busy_n;
      default: return busy;
    endcase
  endfunction

  function automatic logic [W-1:0] get_out(input int sel);
    case (sel)
      1:       return out_z;
      2:       return out_n;
      default: return out;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      1:       start_z = v;
      2:       start_n = v;
      default: start = v;
    endcase
  endtask

  // One request on instance sel; checks latency, result, out hold, busy, return to idle.
  task automatic run_op(input int sel, input string tag, input logic [W-1:0] a,
                        input logic n, input logic m, input logic [W-1:0] exp,
                        input int lat, input bit scramble);
    int           seen;
    bit           hold_ok, busy_ok;
    logic [W-1:0] prev;
    seen = 0;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    prev = get_out(sel);
    acc = a;
    neg = n;
    norm = m;
    set_start(sel, 1'b1);
    for (int c = 1; c <= 45 && seen == 0; c++) begin
      tick();
      set_start(sel, scramble && (c == 3));
      if (scramble) begin
        acc  = (c == 3) ? 32'd5000 : $urandom;
        neg  = 1'($urandom);
        norm = 1'($urandom);
      end
      if (get_done(sel) === 1'b1) begin
        seen = c;
        check({tag, " busy_at_done"}, W'(get_busy(sel)), W'(1));
      end else begin
        if (get_out(sel) !== prev) hold_ok = 1'b0;
        if (get_busy(sel) !== 1'b1) busy_ok = 1'b0;
      end
    end
    set_start(sel, 1'b0);
    check({tag, " latency"}, W'(seen), W'(lat));
    check({tag, " out"}, get_out(sel), exp);
    check({tag, " out_hold"}, W'(hold_ok), W'(1));
    check({tag, " busy_during"}, W'(busy_ok), W'(1));
    tick();
    check({tag, " done_after"}, W'(get_done(sel)), W'(0));
    check({tag, " busy_after"}, W'(get_busy(sel)), W'(0));
  endtask

  initial begin
    int d1, d2, d3, nd;
    bit no_done;

    // Asynchronous reset at power-up, observed before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst out", out, '0);
    check("rst busy", W'(busy), W'(0));
    check("rst done", W'(done), W'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Normalization
    run_op(0, "div1000", 32'd1000, 1'b0, 1'b1, 32'd7, 33, 1'b0);
    run_op(0, "div8000", 32'h8000_0000, 1'b0, 1'b1, 32'h0100_0000, 33, 1'b0);

    // Positive-set and pass-through, back to back
    run_op(0, "pset_neg", 32'hFFFF_FF00, 1'b1, 1'b0, 32'h0, 1, 1'b0);
    run_op(0, "pset_pos", 32'h0000_0050, 1'b1, 1'b0, 32'h50, 1, 1'b0);
    run_op(0, "both11", 32'h0000_1234, 1'b1, 1'b1, 32'h1234, 1, 1'b0);
    run_op(0, "pass00", 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1, 1'b0);
    run_op(0, "pass00_neg", 32'h8000_0001, 1'b0, 1'b0, 32'h8000_0001, 1, 1'b0);

    // Start during divide ignored; inputs changing after acceptance
    run_op(0, "div_ign", 32'd1000, 1'b0, 1'b1, 32'd7, 33, 1'b1);

    // Start held high: accepted every 34 cycles
    d1 = 0; d2 = 0; d3 = 0; nd = 0;
    acc = 32'd1000; neg = 1'b0; norm = 1'b1; start = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      tick();
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) d1 = c;
        else if (nd == 2) d2 = c;
        else if (nd == 3) d3 = c;
      end
    end
    start = 1'b0;
    check("held done1", W'(d1), W'(33));
    check("held done2", W'(d2), W'(67));
    check("held done3", W'(d3), W'(101));
    check("held count", W'(nd), W'(3));
    check("held out", out, 32'd7);
    for (int c = 0; c < 40; c++) tick();

    // Reset mid-divide: immediate, no done afterwards
    acc = 32'd1000; neg = 1'b0; norm = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst busy", W'(busy), W'(0));
    check("midrst done", W'(done), W'(0));
    check("midrst out", out, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    no_done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    check("midrst quiet", W'(no_done), W'(1));
    run_op(0, "div256", 32'd256, 1'b0, 1'b1, 32'd2, 33, 1'b0);

    // Edge operands
    run_op(0, "div0", 32'd0, 1'b0, 1'b1, 32'd0, 33, 1'b0);
    run_op(0, "divmax", 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h01FF_FFFF, 33, 1'b0);
    run_op(1, "gain0", 32'h1234_5678, 1'b0, 1'b1, 32'hFFFF_FFFF, 33, 1'b0);
    run_op(2, "nonorm", 32'hABCD_0001, 1'b0, 1'b1, 32'hABCD_0001, 1, 1'b0);
    check("nonorm main_out_hold", out, 32'h01FF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/norm_seq_fx.md
Name: norm_seq_fx

Overview:
Sequential post-processing unit for the fixed-point accumulator path. It applies one of three operations to a captured accumulator value: pass-through, positive-set clamp, or normalization by NUGAIN. The normalization divide is an iterative multi-cycle operation, replacing a single-cycle combinational divider. It sits between the ALU accumulator and the writeback/output path, and uses a start/busy/done handshake so the core can stall while a divide is in flight.

Parameters:
- NUBITS, 32, data width of acc and out.
- NUGAIN, 128 (NUBITS wide), unsigned divisor for normalization.
- NORMS, 1, enables the normalization divider; when 0, a norm request behaves as pass-through.
- PSET, 1, enables the positive-set clamp; when 0, a neg request behaves as pass-through.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- start  in  1  request strobe; sampled only in IDLE.
- acc  in  NUBITS  operand; captured on accepted start.
- neg  in  1  positive-set request; captured with acc.
- norm  in  1  normalize request; captured with acc.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse; out is valid from this cycle onward.
- out  out  NUBITS  registered result; holds until the next done.

Behaviour:
- Reset (asynchronous, active high):
  - state=IDLE, out=0, done=0, busy=0, and all internal registers cleared.
  - Reset mid-operation aborts immediately. No done is produced and out returns to 0.
- States: IDLE, DIV, FIN.
  - busy = (state != IDLE).
  - done = (state == FIN).
- IDLE:
  - start=1 in cycle T accepts the request and captures acc, neg, norm.
  - The operation is selected from {neg,norm}.
  - 2'b01 with NORMS=1: load dividend=acc, remainder=0, iteration counter=NUBITS-1, go to DIV.
  - Any other combination: compute the result into out at the T→T+1 edge, go to FIN. Done is therefore seen at T+1 (latency 1).
    - 2'b10 with PSET=1: out = 0 if acc[NUBITS-1]=1, else acc.
    - 2'b00, 2'b11, and any disabled mode: out = acc (pass-through).
- DIV (unsigned restoring division, one quotient bit per cycle, MSB first):
  - Each cycle: rem' = {rem, dividend MSB}, an NUBITS+1-bit value. If rem' >= NUGAIN, subtract NUGAIN and shift in quotient bit 1; else shift in 0. Shift the dividend left by one.
  - The DIV state lasts exactly NUBITS cycles (T+1 .. T+NUBITS).
  - On the final iteration the quotient is written to out and the state goes to FIN. Done is at T+NUBITS+1.
  - Result equals floor(acc/NUGAIN), with acc treated as unsigned. Remainder is discarded.
  - NUGAIN=0: result is all ones. This is defined behaviour, not an error.
- FIN: done=1 for exactly one cycle, then IDLE unconditionally. start is ignored in FIN.
- start while busy (DIV or FIN) is ignored; no queueing.
- Changes on acc/neg/norm after acceptance do not affect the in-flight result.
- Back-to-back requests:
  - A start in the cycle after FIN (i.e. in IDLE) is accepted.
  - Minimum request spacing is 2 cycles for non-divide operations and NUBITS+2 cycles for divides.
- out changes only on the edge entering FIN (or on reset). out is stable in all other cycles.

Test Plan:
All cases use NUBITS=32, NUGAIN=128, NORMS=1, PSET=1.
1. Reset: assert rst asynchronously between edges → out=0, busy=0, done=0 immediately, without waiting for a clock edge.
2. Normalize: start with acc=1000, neg=0, norm=1 at cycle T → busy high T+1..T+33, done pulse at T+33 only, out=7. Repeat with acc=0x80000000 → out=0x01000000 (unsigned).
3. Positive-set:
   - acc=0xFFFFFF00, neg=1, norm=0 → done at T+1, out=0.
   - acc=0x00000050, neg=1 → out=0x50.
   - acc=0x1234, neg=1, norm=1 → out=0x1234 (pass-through).
4. Handshake robustness:
   - During a divide of acc=1000, pulse start with acc=5000 and change acc every cycle → second start ignored, single done, out=7.
   - start held high continuously → requests accepted at T, T+34, T+68 (divides).
5. Reset mid-divide: assert rst at cycle T+10 of a divide → busy=0, out=0, no done. A new divide start with acc=256 → out=2 after 33 cycles.
6. Edge operands:
   - acc=0 norm → out=0.
   - acc=0xFFFFFFFF norm → out=0x01FFFFFF.
   - Separate instance with NUGAIN=0 → out=0xFFFFFFFF.
   - Separate instance with NORMS=0, norm request → out=acc, done at T+1.
